// File: rtl/move_request_gen.sv
// Debounced switch levels -> 1-cycle move / chord-reset requests, all outputs registered one cycle after the sampling edge.
// Optional hold-to-repeat is compiled in with `define AUTO_REPEAT_EN; without it each clean press yields exactly one move.
module move_request_gen #(
  parameter int unsigned CLK_HZ       = 25_000_000,
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned CHORD_CYCLES = 25_000_000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switches,
  output logic       o_Move_Left,
  output logic       o_Move_Down,
  output logic       o_Move_Up,
  output logic       o_Move_Right,
  output logic       o_Chord_Reset,
  output logic       o_Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    REPEAT = 3'd2,
    MULTI  = 3'd3,
    CHORD  = 3'd4,
    LOCK   = 3'd5
  } state_t;

  // Parameters a build may not otherwise touch are referenced here; no logic results.
  if (CLK_HZ == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0 || CHORD_CYCLES == 0) begin : g_param_ref
  end

  localparam logic [CNT_W-1:0] CHORD_LAST = CNT_W'(CHORD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] timer_inc;
  logic [3:0]       dir_q, dir_d;
  logic [3:0]       move_q, move_d;
  logic             chord_q, chord_d;
  logic             busy_q, busy_d;
  logic [2:0]       pop;

  assign pop = {2'b00, i_Switches[0]} + {2'b00, i_Switches[1]}
             + {2'b00, i_Switches[2]} + {2'b00, i_Switches[3]};

  // Timer saturates at all-ones instead of wrapping.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    move_d  = 4'b0000;
    chord_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop == 3'd1) begin
          move_d  = i_Switches;
          dir_d   = i_Switches;
          timer_d = '0;
          state_d = HOLD;
        end else if (pop == 3'd4) begin
          timer_d = '0;
          state_d = CHORD;
        end else if (pop != 3'd0) begin
          state_d = MULTI;
        end
      end
      HOLD, REPEAT: begin
        if (i_Switches == dir_q) begin
`ifdef AUTO_REPEAT_EN
          if (timer_q == ((state_q == HOLD) ? DELAY_LAST : RATE_LAST)) begin
            move_d  = dir_q;
            timer_d = '0;
            state_d = REPEAT;
          end else begin
            timer_d = timer_inc;
          end
`else
          timer_d = timer_inc;
`endif
        end else if (pop == 3'd0) begin
          state_d = IDLE;
        end else if (pop == 3'd4) begin
          timer_d = '0;
          state_d = CHORD;
        end else begin
          // Includes a same-cycle swap to another single direction.
          state_d = MULTI;
        end
      end
      MULTI: begin
        if (pop == 3'd4) begin
          timer_d = '0;
          state_d = CHORD;
        end else if (pop == 3'd0) begin
          state_d = IDLE;
        end
      end
      CHORD: begin
        if (pop == 3'd4) begin
          if (timer_q == CHORD_LAST) begin
            chord_d = 1'b1;
            state_d = LOCK;
          end else begin
            timer_d = timer_inc;
          end
        end else if (pop == 3'd0) begin
          state_d = IDLE;
        end else begin
          state_d = MULTI;
        end
      end
      LOCK: begin
        if (pop == 3'd0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= 4'b0000;
      move_q  <= 4'b0000;
      chord_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      chord_q <= chord_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Move_Left   = move_q[0];
  assign o_Move_Down   = move_q[1];
  assign o_Move_Up     = move_q[2];
  assign o_Move_Right  = move_q[3];
  assign o_Chord_Reset = chord_q;
  assign o_Busy        = busy_q;

endmodule
